// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types, default constants and PC-to-word-address helper
//                for the fetch sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
  localparam int          DEF_ADDR_W   = 12;

  // Modular offset from the IM base; callers truncate to their address width.
  function automatic logic [31:0] pc_to_waddr(input logic [31:0] pc, input logic [31:0] base);
    logic [31:0] off;
    off = pc - base;
    return off >> 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_slot.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_slot
//  Description : IF/ID output register holding one PC+instruction with
//                load / accept / flush control.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic        i_accept,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (i_load) begin
      valid_d = 1'b1;
      pc_d    = i_pc;
      instr_d = i_instr;
    end else if (valid_q && i_accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_pc    = pc_q;
  assign o_instr = instr_q;

endmodule
`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_seq
//  Description : Stall- and redirect-aware PC sequencer and IM fetch controller
//                for the IF stage. Optional exception entry with FETCH_EXC_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter logic [31:0] EXC_PC   = DEF_EXC_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redir_valid,
  input  logic [31:0]       redir_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  output logic              align_err
`ifdef FETCH_EXC_EN
  ,
  input  logic              exc_req,
  output logic [31:0]       epc
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         pend_q, pend_d;
  logic         align_err_q, align_err_d;

  logic         w_redir_any;
  logic [31:0]  w_redir_tgt;
  logic         w_slot_free;
  logic         w_load;

`ifdef FETCH_EXC_EN
  logic [31:0] epc_q, epc_d;

  // Exception entry outranks a simultaneous branch redirect.
  assign w_redir_any = exc_req | redir_valid;
  assign w_redir_tgt = exc_req ? EXC_PC : {redir_pc[31:2], 2'b00};
  assign align_err_d = redir_valid & ~exc_req & (|redir_pc[1:0]);

  always_comb begin
    epc_d = epc_q;
    if (exc_req) begin
      epc_d = if_valid ? if_pc : pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      epc_q <= '0;
    end else begin
      epc_q <= epc_d;
    end
  end

  assign epc = epc_q;
`else
  logic w_unused_exc;

  assign w_redir_any  = redir_valid;
  assign w_redir_tgt  = {redir_pc[31:2], 2'b00};
  assign align_err_d  = redir_valid & (|redir_pc[1:0]);
  assign w_unused_exc = ^EXC_PC;
`endif

  assign w_slot_free = !if_valid || if_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      pend_pc_q   <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      align_err_q <= align_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    w_load    = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
        if (w_redir_any) pc_d = w_redir_tgt;
      end
      ST_REQ: begin
        if (imem_ack) begin
          if (w_redir_any) begin
            pc_d   = w_redir_tgt;
            pend_d = 1'b0;
          end else if (pend_q) begin
            pc_d   = pend_pc_q;
            pend_d = 1'b0;
          end else if (w_slot_free) begin
            w_load  = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = if_ready ? ST_REQ : ST_HOLD;
          end else begin
            // Slot still owned by a stalled instruction: drop the word and refetch this PC later.
            state_d = ST_HOLD;
          end
        end else if (w_redir_any) begin
          pend_d    = 1'b1;
          pend_pc_d = w_redir_tgt;
        end
      end
      ST_HOLD: begin
        if (w_redir_any) begin
          pc_d    = w_redir_tgt;
          state_d = ST_REQ;
        end else if (w_slot_free) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == ST_REQ);
    imem_addr = ADDR_W'(pc_to_waddr(pc_q, RESET_PC));
  end

  assign align_err = align_err_q;

  fetch_slot u_slot (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_flush  (w_redir_any),
    .i_accept (if_ready),
    .i_pc     (pc_q),
    .i_instr  (imem_rdata),
    .o_valid  (if_valid),
    .o_pc     (if_pc),
    .o_instr  (if_instr)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_seq
//  Description : Self-checking bench for fetch_seq: directed scenarios plus
//                randomized stall/redirect/reset traffic against a stream model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_seq;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          AW     = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          redir_valid = 1'b0;
  logic [31:0]   redir_pc = '0;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          if_ready = 1'b1;
  logic          imem_req, if_valid, align_err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   if_pc, if_instr;
`ifdef FETCH_EXC_EN
  logic          exc_req = 1'b0;
  logic [31:0]   epc;
`endif

  fetch_seq #(.RESET_PC(RST_PC), .ADDR_W(AW), .EXC_PC(32'h0000_4180)) dut (
    .clk         (clk),
    .reset       (reset),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .align_err   (align_err)
`ifdef FETCH_EXC_EN
    ,
    .exc_req     (exc_req),
    .epc         (epc)
`endif
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [31:0]   exp_q[$];
  logic [31:0]   last_pc = RST_PC;
  logic [31:0]   mon_e;
  int            hs_count = 0;
  logic [31:0]   hs_pc = '0;
  logic          exp_align = 1'b0;
  bit            done = 1'b0;
  int            lat_cfg = 1;
  logic          im_busy = 1'b0;
  int            im_cnt = 0;
  logic [AW-1:0] im_addr = '0;

  // Instruction memory content: a distinct word derived from each address.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {4'hC, a, 4'h3, ~a};
  endfunction

  function automatic logic [AW-1:0] waddr_of(input logic [31:0] pc);
    logic [31:0] off;
    off = (pc - RST_PC) / 4;
    return off[AW-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  // Instruction memory: latency counted from the cycle a request is first seen.
  initial forever begin
    @(posedge clk);
    #1;
    if (imem_ack) im_busy = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (!imem_req) begin
      im_busy = 1'b0;
    end else if (!im_busy) begin
      im_busy = 1'b1;
      im_addr = imem_addr;
      im_cnt  = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
    end else begin
      check("imem_addr_stable", 32'(imem_addr), 32'(im_addr));
      im_cnt--;
      if (im_cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(im_addr);
      end
    end
  end

  // Monitor: every accepted instruction must continue the expected PC stream.
  initial forever begin
    @(negedge clk);
    if (!done) check("align_err", 32'(align_err), 32'(exp_align));
    exp_align = reset && redir_valid && (redir_pc[1:0] != 2'b00);
    if (reset && !redir_valid && if_valid && if_ready) begin
      if (exp_q.size() == 0) exp_q.push_back(last_pc + 32'd4);
      mon_e = exp_q.pop_front();
      check("sb_if_pc", if_pc, mon_e);
      check("sb_if_instr", if_instr, mem_word(waddr_of(mon_e)));
      last_pc = mon_e;
      hs_pc   = if_pc;
      hs_count++;
    end
  end

  task automatic wait_hs(input string name, output logic [31:0] pc);
    int start;
    int k;
    start = hs_count;
    k = 0;
    pc = '0;
    while (hs_count == start && k < 80) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (hs_count == start) timeout_fail(name);
    else pc = hs_pc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    redir_valid = 1'b1;
    redir_pc    = target;
    exp_q.delete();
    exp_q.push_back({target[31:2], 2'b00});
  endtask

  initial begin
    logic [31:0] pc;
    int k;
    exp_q.push_back(RST_PC);

    // Reset values
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_align_err", 32'(align_err), 32'd0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("boot_no_req", 32'(imem_req), 32'd0);

    k = 0;
    while (!imem_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!imem_req) timeout_fail("first_req");
    else check("first_addr", 32'(imem_addr), 32'd0);

    wait_hs("hs0", pc); check("first_pc0", pc, 32'h0000_3000);
    wait_hs("hs1", pc); check("first_pc1", pc, 32'h0000_3004);
    wait_hs("hs2", pc); check("first_pc2", pc, 32'h0000_3008);

    // Downstream stall: slot frozen, no fetch, nothing skipped.
    next_cycle();
    if_ready = 1'b0;
    repeat (4) next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(if_valid), 32'd1);
      check("stall_pc", if_pc, 32'h0000_300C);
      check("stall_instr", if_instr, mem_word(12'd3));
      check("stall_no_req", 32'(imem_req), 32'd0);
    end
    next_cycle();
    if_ready = 1'b1;
    wait_hs("stall_hs0", pc); check("stall_release_pc", pc, 32'h0000_300C);
    wait_hs("stall_hs1", pc); check("no_skip_pc", pc, 32'h0000_3010);

    // Redirect while a 3-cycle fetch is outstanding.
    lat_cfg = 3;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(imem_req && im_busy && im_cnt == 3) && k < 20);
    if (!(imem_req && im_busy && im_cnt == 3)) timeout_fail("outst_req");
    next_cycle();
    redirect(32'h0000_3100);
    next_cycle();
    redir_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!imem_ack && k < 10);
    if (!imem_ack) timeout_fail("outst_ack");
    @(negedge clk);
    check("outst_dropped", 32'(if_valid), 32'd0);
    check("outst_req", 32'(imem_req), 32'd1);
    check("outst_addr", 32'(imem_addr), 32'h40);
    wait_hs("outst_hs", pc); check("outst_pc", pc, 32'h0000_3100);

    // Misaligned redirect in the same cycle as an ack.
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(im_busy && im_cnt == 1) && k < 20);
    if (!(im_busy && im_cnt == 1)) timeout_fail("same_ack_wait");
    next_cycle();
    redirect(32'h0000_3202);
    next_cycle();
    redir_valid = 1'b0;
    @(negedge clk);
    check("same_align_pulse", 32'(align_err), 32'd1);
    @(negedge clk);
    check("same_align_clear", 32'(align_err), 32'd0);
    wait_hs("same_hs", pc); check("same_pc", pc, 32'h0000_3200);
    lat_cfg = 1;

    // Reset in HOLD.
    next_cycle();
    if_ready = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(if_valid && !imem_req) && k < 20);
    if (!(if_valid && !imem_req)) timeout_fail("hold_wait");
    next_cycle();
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(RST_PC);
    next_cycle();
    reset    = 1'b1;
    if_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(if_valid), 32'd0);
    check("mid_rst_pc", if_pc, 32'd0);
    check("mid_rst_instr", if_instr, 32'd0);
    check("mid_rst_req", 32'(imem_req), 32'd0);
    wait_hs("mid_rst_hs", pc); check("mid_rst_restart", pc, 32'h0000_3000);

    // Randomized traffic.
    lat_cfg = 0;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      if_ready = ($urandom_range(0, 3) != 0);
      if (!reset) begin
        reset = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        reset       = 1'b0;
        redir_valid = 1'b0;
        exp_q.delete();
        exp_q.push_back(RST_PC);
      end else if ($urandom_range(0, 14) == 0) begin
        redirect(RST_PC + ($urandom_range(0, 1023) << 2) +
                 (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 32'd0));
      end else begin
        redir_valid = 1'b0;
      end
    end

    // Drain: the stream must still make progress.
    next_cycle();
    reset       = 1'b1;
    redir_valid = 1'b0;
    if_ready    = 1'b1;
    wait_hs("drain_hs0", pc);
    wait_hs("drain_hs1", pc);
    @(negedge clk);
    done = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
